mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one 32x32 unsigned Wallace-tree multiplier among NREQ requesters in the matrix-multiply datapath. It grants one operand pair per cycle to the external combinational multiplier and captures the 64-bit product into a tagged output register. The output register is held under downstream backpressure. The block owns all sequencing; the multiplier itself stays purely combinational.

---
 rtl/mult_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational W x W multiplier among NREQ requesters.
// Optional macro MULT_OPREG_EN inserts an operand register stage ahead of the multiplier (latency 2).
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    output logic [NREQ-1:0]     req_ready_o,
    input  logic [NREQ*W-1:0]   req_a_i,
    input  logic [NREQ*W-1:0]   req_b_i,
    output logic [W-1:0]        mul_a_o,
    output logic [W-1:0]        mul_b_o,
    input  logic [2*W-1:0]      mul_p_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [IDW-1:0]      rsp_id_o,
    output logic [2*W-1:0]      rsp_data_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] win_id;
    logic           any_vld;
    logic           can_issue;
    logic           grant;
    logic           rsp_adv;
    logic           rsp_load;
    logic [IDW-1:0] load_id;
    logic [W-1:0]   sel_a, sel_b;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;

    // First valid requester scanning from ptr upward, wrapping at NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        win_id  = '0;
        any_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!any_vld && req_valid_i[idx]) begin
                any_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    assign sel_a   = req_a_i[int'(win_id)*W +: W];
    assign sel_b   = req_b_i[int'(win_id)*W +: W];
    assign rsp_adv = !rsp_valid_q || rsp_ready_i;
    assign grant   = any_vld && can_issue;

    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[win_id] = 1'b1;
    end

`ifdef MULT_OPREG_EN
    logic           op_valid_q, op_valid_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic           op_adv;

    // The operand stage empties into the result register whenever that register can accept.
    assign op_adv    = op_valid_q && rsp_adv;
    assign can_issue = !op_valid_q || op_adv;
    assign rsp_load  = op_adv;
    assign load_id   = op_id_q;
    assign mul_a_o   = op_valid_q ? op_a_q : '0;
    assign mul_b_o   = op_valid_q ? op_b_q : '0;

    always_comb begin
        op_valid_d = op_valid_q;
        op_id_d    = op_id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        if (grant) begin
            op_valid_d = 1'b1;
            op_id_d    = win_id;
            op_a_d     = sel_a;
            op_b_d     = sel_b;
        end else if (op_adv) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_valid_q <= 1'b0;
            op_id_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_id_q    <= op_id_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
        end
    end
`else
    assign can_issue = rsp_adv;
    assign rsp_load  = grant;
    assign load_id   = win_id;
    assign mul_a_o   = grant ? sel_a : '0;
    assign mul_b_o   = grant ? sel_b : '0;
`endif

    // A load in the same cycle as a drain overwrites the old result, keeping throughput at one per cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        ptr_d       = ptr_q;
        if (rsp_load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = load_id;
            rsp_data_d  = mul_p_i;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        if (grant) ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with an ideal multiplier model.
// Works in both builds; MULT_OPREG_EN selects the expected latency.
module tb_mult_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;
`ifdef MULT_OPREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [W-1:0]        mul_a, mul_b;
    logic [2*W-1:0]      mul_p;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [2*W-1:0]      rsp_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_p_i     (mul_p),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; optionally withdraw requests that were granted at that edge.
    task automatic step(input bit drop);
        logic [NREQ-1:0] g;
        g = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (drop) req_valid = req_valid & ~g;
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 8) begin
            step(1);
            n++;
        end
        if (!rsp_valid) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic single(input string tag, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        set_op(id, a, b);
        req_valid = 4'b0001 << id;
        #1;
        check_eq({tag, "_ready"}, req_ready, 4'b0001 << id);
        step(1);
        for (int i = 1; i < LAT; i++) begin
            check_eq({tag, "_early"}, rsp_valid, 0);
            step(1);
        end
        check_eq({tag, "_valid"}, rsp_valid, 1);
        check_eq({tag, "_id"}, rsp_id, id);
        check_eq({tag, "_data"}, rsp_data, exp);
        step(1);
        check_eq({tag, "_drained"}, rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        step(1); step(1);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        check_eq("rst_valid", rsp_valid, 0);
        check_eq("rst_id", rsp_id, 0);
        check_eq("rst_data", rsp_data, 0);

        // 0x01010010 * 0x01010014 = 2^48 + 2^41 + 2^32 + 36*2^24 + 36*2^16 + 320
        single("single", 1, 32'h0101_0010, 32'h0101_0014, 64'h0001_0201_2424_0140);
        single("max", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        single("zero", 3, 32'h0, 32'h0101_0010, 64'h0);

        // Round robin from a freshly reset pointer.
        rst = 1'b1; step(1); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 2, 3);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k <= LAT + 4; k++) begin
            if (k == 5) req_valid = '0;
            #1;
            check_eq("rr_grant", req_ready, (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000);
            if (k >= LAT) begin
                check_eq("rr_valid", rsp_valid, 1);
                check_eq("rr_id", rsp_id, (k - LAT) % 4);
                check_eq("rr_data", rsp_data, ((k - LAT) % 4 + 2) * 3);
            end
            step(0);
        end
        check_eq("rr_empty", rsp_valid, 0);

        // Backpressure; pointer is now 1, so requester 2 wins before 0.
        set_op(0, 7, 11);
        set_op(2, 13, 17);
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        #1;
        check_eq("bp_first", req_ready, 4'b0100);
        step(1);
        wait_rsp("bp");
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_id", rsp_id, 2);
            check_eq("bp_data", rsp_data, 221);
            check_eq("bp_ready", req_ready, 0);
            step(1);
        end
        rsp_ready = 1'b1;
        #1;
        step(1);
        check_eq("bp_second_valid", rsp_valid, 1);
        check_eq("bp_second_id", rsp_id, 0);
        check_eq("bp_second_data", rsp_data, 77);
        step(1);
        check_eq("bp_done", rsp_valid, 0);

        // Idle; pointer sits at 1 and must not move.
        for (int k = 0; k < 10; k++) begin
            check_eq("idle_mul_a", mul_a, 0);
            check_eq("idle_mul_b", mul_b, 0);
            check_eq("idle_ready", req_ready, 0);
            step(1);
        end
        req_valid = 4'b1111;
        #1;
        check_eq("idle_ptr", req_ready, 4'b0010);
        req_valid = '0;
        #1;

        // Reset with an operation in flight; pointer would otherwise favour 3 over 1.
        set_op(1, 5, 5);
        req_valid = 4'b0010;
        #1;
        step(1);
        rst = 1'b1;
        req_valid = '0;
        #1;
        step(1);
        rst = 1'b0;
        #1;
        check_eq("mrst_ready", req_ready, 0);
        check_eq("mrst_mul_a", mul_a, 0);
        check_eq("mrst_mul_b", mul_b, 0);
        check_eq("mrst_valid", rsp_valid, 0);
        check_eq("mrst_id", rsp_id, 0);
        check_eq("mrst_data", rsp_data, 0);
        step(1);
        check_eq("mrst_stale", rsp_valid, 0);
        set_op(1, 6, 7);
        set_op(3, 2, 9);
        req_valid = 4'b1010;
        #1;
        check_eq("mrst_lowest", req_ready, 4'b0010);
        step(1);
        wait_rsp("mrst");
        check_eq("mrst_id1", rsp_id, 1);
        check_eq("mrst_data1", rsp_data, 42);
        step(1);
        check_eq("mrst_valid3", rsp_valid, 1);
        check_eq("mrst_id3", rsp_id, 3);
        check_eq("mrst_data3", rsp_data, 18);
        step(1);
        check_eq("mrst_end", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
